// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. It accepts two WIDTH-bit operands on a
// valid/ready handshake, adds them LSB-first one bit per clock with a
// full adder built from two half adders and a registered carry, and
// returns the sum and carry-out on a second valid/ready handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' port is added. With sub=1 the block computes
//   (a - b) mod 2^WIDTH as a + ~b + 1, and carry=1 means "no borrow".

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cr_q, cr_d;

    // Operand B and the initial carry as loaded on the input handshake.
    logic [WIDTH-1:0] b_load;
    logic             cr_init;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtraction: invert B and inject a carry-in of 1.
    assign b_load  = sub ? ~b : b;
    assign cr_init = sub;
`else
    assign b_load  = b;
    assign cr_init = 1'b0;
`endif

    // Full-adder cell: two half adders on the current LSBs plus the registered carry.
    logic s0, c0, s_bit, c1;
    assign s0    = a_q[0] ^ b_q[0];
    assign c0    = a_q[0] & b_q[0];
    assign s_bit = s0 ^ cr_q;
    assign c1    = s0 & cr_q;

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cr_d    = cr_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_load;
                    cnt_d   = '0;
                    cr_d    = cr_init;
                    state_d = RUN;
                end
            end
            RUN: begin
                cr_d  = c0 | c1;
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the first result bit.
                sum_d = {s_bit, sum_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so no stale result is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, because sum/carry are visible outputs.
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same old values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cr_q    <= cr_d;
        end
    end

    // Outputs come straight from registers or state decode.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign carry     = cr_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8). Build with +define+SERIAL_ADDER_SUB_EN
// to also exercise the subtract mode.

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             sb;
        int               hold;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic; subtraction as a + 2^WIDTH - b.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic sb);
        longint unsigned full;
        if (sb) full = longint'(x) + (longint'(1) << WIDTH) - longint'(y);
        else    full = longint'(x) + longint'(y);
        return full[WIDTH:0];
    endfunction

    // Wait for out_valid after an accept edge; returns cycles since the accept cycle.
    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && n < WIDTH + 8) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // One full transaction; called at #1 after a clock edge with the block in IDLE.
    task automatic do_op(input string nm, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic sb, input int hold,
                         input logic [WIDTH-1:0] es, input logic ec);
        int n;
        check({nm, "_in_ready_before"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = sb;
`else
        if (sb) begin
            failures++;
            $display("FAIL %s subtract requested in add-only build", nm);
        end
`endif
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        wait_done(n);
        check({nm, "_latency"}, n, WIDTH + 1);
        for (int i = 0; i < hold; i++) begin
            check({nm, "_hold_valid"}, out_valid, 1);
            check({nm, "_hold_sum"}, sum, es);
            check({nm, "_hold_carry"}, carry, ec);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check({nm, "_sum"}, sum, es);
        check({nm, "_carry"}, carry, ec);
        @(posedge clk); #1;
        check({nm, "_valid_after"}, out_valid, 0);
        check({nm, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n;
        int               bad;
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        int               rh;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sum", sum, 0);
        check("reset_carry", carry, 0);

        // Directed vectors with hand-derived expectations.
        vecs.push_back('{"zero",    8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0});
        vecs.push_back('{"ff_01",   8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1});
        vecs.push_back('{"a5_5a",   8'hA5, 8'h5A, 1'b0, 0, 8'hFF, 1'b0});
        vecs.push_back('{"bp_80",   8'h80, 8'h80, 1'b0, 5, 8'h00, 1'b1});
        vecs.push_back('{"ff_ff",   8'hFF, 8'hFF, 1'b0, 2, 8'hFE, 1'b1});
        vecs.push_back('{"one_two", 8'h01, 8'h02, 1'b0, 1, 8'h03, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{"sub_5_7", 8'h05, 8'h07, 1'b1, 0, 8'hFE, 1'b0});
        vecs.push_back('{"sub_7_5", 8'h07, 8'h05, 1'b1, 0, 8'h02, 1'b1});
        vecs.push_back('{"sub_0_0", 8'h00, 8'h00, 1'b1, 1, 8'h00, 1'b1});
`endif
        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].sb, vecs[i].hold,
                  vecs[i].exp_sum, vecs[i].exp_carry);
        end

        // in_valid held high with changing operands during RUN: no second accept, result unaffected,
        // and the next accept happens exactly WIDTH+2 cycles after the first.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'hA5;
        b         = 8'h5A;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        @(posedge clk); #1;
        n   = 1;
        bad = 0;
        while (!out_valid && n < WIDTH + 8) begin
            if (in_ready || !busy) bad++;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check("hold_iv_latency", n, WIDTH + 1);
        check("hold_iv_no_accept_in_run", bad, 0);
        check("hold_iv_sum", sum, 8'hFF);
        check("hold_iv_carry", carry, 0);
        check("hold_iv_ready_in_done", in_ready, 0);
        @(posedge clk); #1;
        n++;
        check("hold_iv_interval", n, WIDTH + 2);
        check("hold_iv_ready_again", in_ready, 1);
        a = 8'h11;
        b = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(n);
        check("hold_iv2_latency", n, WIDTH + 1);
        check("hold_iv2_sum", sum, 8'h33);
        check("hold_iv2_carry", carry, 0);
        @(posedge clk); #1;

        // Reset asserted in the 4th RUN cycle aborts to reset values.
        in_valid = 1'b1;
        a        = 8'h3C;
        b        = 8'h0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_abort", 8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0);

        // Randomized operands against the arithmetic reference model.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            rh = $urandom_range(0, 3);
            r  = model(ra, rb, rs);
            do_op("rand", ra, rb, rs, rh, r[WIDTH-1:0], r[WIDTH]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder stage that drives the half-adder datapath one bit per clock. It accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first. The full-adder cell is built from two half-adder cells plus a registered carry. It returns the WIDTH-bit sum and the final carry on a second valid/ready handshake. It trades latency for area in front of result consumers.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A, sampled on the input handshake
- b  input  WIDTH  operand B, sampled on the input handshake
- out_valid  output  1  sum and carry are valid (high only in DONE)
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result bits, registered
- carry  output  1  carry out of the MSB, registered
- busy  output  1  high in RUN or DONE
- sub  input  1  subtract select; present only when SERIAL_ADDER_SUB_EN is defined

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - load a into shift register A and b into shift register B;
    - clear bit counter to 0;
    - initialise carry register to 0;
    - go to RUN.
- RUN, each cycle:
  - s0 = A[0]^B[0]; c0 = A[0]&B[0] (half adder 1);
  - s = s0^cr; c1 = s0&cr (half adder 2);
  - cr <= c0|c1;
  - shift s into sum register from the MSB side (sum >> 1, s at bit WIDTH-1);
  - shift A and B right by one;
  - increment counter.
- RUN exit: after the cycle that processes counter==WIDTH-1, go to DONE. sum then holds the full result in bit order, and carry = final cr.
- DONE:
  - out_valid=1; sum and carry held stable.
  - On out_valid&&out_ready, go to IDLE.
- Arithmetic: sum = (a+b) mod 2^WIDTH; carry = bit WIDTH of a+b. No saturation.
- in_valid is ignored outside IDLE. Operand inputs are don't-care except on the input handshake.
- Reset values:
  - state=IDLE, counter=0, cr=0, shift registers=0;
  - in_ready=1, out_valid=0, busy=0;
  - sum=0, carry=0.
- Asserting rst_n low at any time, including mid-RUN or in DONE, aborts the operation immediately to reset values. No partial result is ever presented.

## Timing
- Input handshake in cycle t.
- RUN occupies cycles t+1 .. t+WIDTH.
- out_valid rises at cycle t+WIDTH+1. Latency is WIDTH+1 cycles.
- Result held indefinitely while out_ready=0. sum, carry and out_valid must not change under backpressure.
- The output handshake completes in cycle u. The block is in IDLE, with in_ready=1, at cycle u+1.
- Minimum issue interval with out_ready tied high: WIDTH+2 cycles.
- out_ready asserted before out_valid has no effect.
- in_ready and out_valid are never high in the same cycle.
- All outputs are driven from registers or state decode only. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists and is sampled on the input handshake;
  - when sub=1, B is loaded as ~b and cr initialises to 1, so sum = (a-b) mod 2^WIDTH;
  - with sub=1, carry=1 means no borrow (a>=b unsigned) and carry=0 means borrow.
- SERIAL_ADDER_SUB_EN undefined: no sub port; addition only; cr always initialises to 0.

## Test plan
- WIDTH=8, a=8'h00, b=8'h00, out_ready=1 -> out_valid exactly 9 cycles after the handshake; sum=8'h00, carry=0; in_ready=1 on the following cycle.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry=1.
- a=8'hA5, b=8'h5A -> sum=8'hFF, carry=0. Hold in_valid=1 with different a, b during RUN -> result unaffected, and no second accept until IDLE.
- a=8'h80, b=8'h80 with out_ready=0 for 5 cycles after out_valid -> sum=8'h00, carry=1, stable for all 5 cycles; out_valid drops the cycle after out_ready=1.
- Pull rst_n low at the 4th RUN cycle of a=8'h3C, b=8'h0F -> immediately state=IDLE, in_ready=1, out_valid=0, sum=8'h00, carry=0. A new a=8'h01, b=8'h02 then yields sum=8'h03, carry=0.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=8'h05, b=8'h07 -> sum=8'hFE, carry=0;
  - a=8'h07, b=8'h05 -> sum=8'h02, carry=1.
